// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, scan FSM states and pixel address helper
package fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int COLOUR_W = 3;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int FB_AW    = $clog2(FB_DEPTH);
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CNT_W    = 16;

  // Sized copies of the geometry so comparisons against 8/7-bit coordinates stay width-exact
  localparam logic [XW-1:0] X_LIMIT = XW'(FB_W);
  localparam logic [YW-1:0] Y_LIMIT = YW'(FB_H);
  localparam logic [XW-1:0] X_LAST  = XW'(FB_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FB_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } fb_state_t;

  // Linear address y*FB_W + x, done entirely in FB_AW bits; in-range inputs never overflow
  function automatic logic [FB_AW-1:0] fb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [FB_AW-1:0] row_base;
    row_base = FB_AW'(y) * FB_AW'(FB_W);
    return row_base + FB_AW'(x);
  endfunction

endpackage

// File: rtl/fb_plot_sink_if.sv
// rtl/fb_plot_sink_if.sv - plot input, readback stream and status bundle for fb_plot_sink
interface fb_plot_sink_if;
  import fb_pkg::*;

  // Plot side (driven by fillers/drawers)
  logic [XW-1:0]       vga_x;
  logic [YW-1:0]       vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  // Readback control and pixel stream
  logic                rd_start;
  logic                pix_valid;
  logic                pix_ready;
  logic [XW-1:0]       pix_x;
  logic [YW-1:0]       pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_last;
  logic                done;

  // Statistics
  logic [CNT_W-1:0]    plot_count;
  logic [CNT_W-1:0]    drop_count;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, rd_start, pix_ready,
    input  pix_valid, pix_x, pix_y, pix_colour, pix_last, done, plot_count, drop_count
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, rd_start, pix_ready,
    output pix_valid, pix_x, pix_y, pix_colour, pix_last, done, plot_count, drop_count
  );

endinterface

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port framebuffer RAM, one write port, one registered read port
module fb_ram
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [FB_AW-1:0]    waddr,
  input  logic [COLOUR_W-1:0] wdata,
  input  logic                re,
  input  logic [FB_AW-1:0]    raddr,
  output logic [COLOUR_W-1:0] rdata
);

  logic [COLOUR_W-1:0] mem [FB_DEPTH];
  logic [COLOUR_W-1:0] rdata_q;

  // Write and read share one edge; the non-blocking read returns the pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_plot_sink.sv
// rtl/fb_plot_sink.sv - plot sink into 160x120x3 framebuffer with raster readback; stats counters under FB_PLOT_STATS_EN
module fb_plot_sink
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fb_plot_sink_if.slave bus
);

  // ---------------------------------------------------------------- plot path
  logic             plot_ok;
  logic [FB_AW-1:0] wr_addr;

  assign plot_ok = bus.vga_plot && (bus.vga_x < X_LIMIT) && (bus.vga_y < Y_LIMIT);
  assign wr_addr = fb_addr(bus.vga_x, bus.vga_y);

  // ---------------------------------------------------------------- scan FSM
  fb_state_t state_q, state_d;
  logic      scan_active;
  logic      scan_start;
  logic      done_o;
  logic      xfer;
  logic      xfer_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: rd_start only matters outside S_SCAN; the scan ends on the pix_last transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.rd_start) state_d = S_SCAN;
      S_SCAN:  if (xfer_last)    state_d = S_DONE;
      S_DONE:  if (bus.rd_start) state_d = S_SCAN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: scan enable, scan restart strobe and the done flag
  always_comb begin
    scan_active = 1'b0;
    scan_start  = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: scan_start = bus.rd_start;
      S_SCAN: scan_active = 1'b1;
      S_DONE: begin
        done_o     = 1'b1;
        scan_start = bus.rd_start;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- readback pipeline
  // Stage 0: read pointer. Stage 1: RAM output register plus its coordinates.
  // Stage 2: pix_* output register. Each stage advances only when the next can take
  // a pixel, and the RAM read is not enabled while stage 1 is blocked, so the RAM
  // output itself holds the stalled pixel.
  logic [XW-1:0]       rd_x_q, rd_x_d;
  logic [YW-1:0]       rd_y_q, rd_y_d;
  logic                issue_done_q, issue_done_d;
  logic                s1_valid_q, s1_valid_d;
  logic [XW-1:0]       s1_x_q, s1_x_d;
  logic [YW-1:0]       s1_y_q, s1_y_d;
  logic                s1_last_q, s1_last_d;
  logic                pix_valid_q, pix_valid_d;
  logic [XW-1:0]       pix_x_q, pix_x_d;
  logic [YW-1:0]       pix_y_q, pix_y_d;
  logic [COLOUR_W-1:0] pix_colour_q, pix_colour_d;
  logic                pix_last_q, pix_last_d;

  logic                out_ready;
  logic                s1_ready;
  logic                issue;
  logic                rd_last;
  logic [FB_AW-1:0]    rd_addr;
  logic [COLOUR_W-1:0] ram_rdata;

  assign xfer      = pix_valid_q && bus.pix_ready;
  assign xfer_last = xfer && pix_last_q;
  assign out_ready = !pix_valid_q || bus.pix_ready;
  assign s1_ready  = !s1_valid_q || out_ready;
  assign issue     = scan_active && !issue_done_q && s1_ready;
  assign rd_last   = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);
  assign rd_addr   = fb_addr(rd_x_q, rd_y_q);

  fb_ram u_ram (
    .clk   (clk),
    .we    (plot_ok),
    .waddr (wr_addr),
    .wdata (bus.vga_colour),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Read pointer: restart at (0,0) on a new scan, walk x fastest, stop after (159,119)
  always_comb begin
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    issue_done_d = issue_done_q;
    if (scan_start) begin
      rd_x_d       = '0;
      rd_y_d       = '0;
      issue_done_d = 1'b0;
    end else if (issue) begin
      issue_done_d = rd_last;
      if (rd_x_q == X_LAST) begin
        rd_x_d = '0;
        rd_y_d = rd_y_q + 7'd1;
      end else begin
        rd_x_d = rd_x_q + 8'd1;
      end
    end
  end

  // Stage 1 tracks the coordinates of the pixel currently sitting in the RAM output register
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_last_d  = s1_last_q;
    if (issue) begin
      s1_valid_d = 1'b1;
      s1_x_d     = rd_x_q;
      s1_y_d     = rd_y_q;
      s1_last_d  = rd_last;
    end else if (out_ready) begin
      s1_valid_d = 1'b0;
    end
  end

  // Output register: loads when empty or when its pixel is being taken, otherwise holds
  always_comb begin
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_colour_d = pix_colour_q;
    pix_last_d   = pix_last_q;
    if (out_ready) begin
      pix_valid_d = s1_valid_q;
      pix_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        pix_x_d      = s1_x_q;
        pix_y_d      = s1_y_q;
        pix_colour_d = ram_rdata;
      end
    end
  end

  // Pipeline registers; reset aborts any scan in progress but leaves the RAM alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      issue_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_last_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      pix_last_q   <= 1'b0;
    end else begin
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      issue_done_q <= issue_done_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_last_q    <= s1_last_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_colour_q <= pix_colour_d;
      pix_last_q   <= pix_last_d;
    end
  end

  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_colour = pix_colour_q;
  assign bus.pix_last   = pix_last_q;
  assign bus.done       = done_o;

  // ---------------------------------------------------------------- statistics
`ifdef FB_PLOT_STATS_EN
  logic             plot_drop;
  logic [CNT_W-1:0] plot_count_q, plot_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  assign plot_drop = bus.vga_plot && !plot_ok;

  // Saturating counters of accepted and dropped plots
  always_comb begin
    plot_count_d = plot_count_q;
    drop_count_d = drop_count_q;
    if (plot_ok && (plot_count_q != '1)) begin
      plot_count_d = plot_count_q + 16'd1;
    end
    if (plot_drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      plot_count_q <= plot_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.plot_count = plot_count_q;
  assign bus.drop_count = drop_count_q;
`else
  assign bus.plot_count = '0;
  assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_plot_sink.sv
// tb/tb_fb_plot_sink.sv - randomized self-checking bench for fb_plot_sink against a 2-D framebuffer model
module tb_fb_plot_sink;

  localparam int W      = 160;
  localparam int H      = 120;
  localparam int NPIX   = W * H;
  localparam int BUDGET = 60000;

`ifdef FB_PLOT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_plot_sink_if pif();

  fb_plot_sink dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif.slave)
  );

  logic [2:0] fb   [H][W];
  logic [2:0] snap [H][W];
  int exp_plot;
  int exp_drop;
  int checks;
  int errors;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [15:0] exp_cnt(input int v);
    return STATS ? 16'(sat16(v)) : 16'd0;
  endfunction

  // One plot strobe for the following edge; the model applies the frame rules
  task automatic plot_px(input int x, input int y, input int c);
    pif.vga_x      = 8'(x);
    pif.vga_y      = 7'(y);
    pif.vga_colour = 3'(c);
    pif.vga_plot   = 1'b1;
    @(posedge clk); #1;
    if (x < W && y < H) begin
      fb[y][x] = 3'(c);
      exp_plot = sat16(exp_plot + 1);
    end else begin
      exp_drop = sat16(exp_drop + 1);
    end
  endtask

  // Full-frame readback: mode 0 = always ready, mode 1 = ready toggling with stray rd_start
  task automatic run_scan(input string tag, input int mode, input int abort_at,
                          input int inj_k, input int inj_x, input int inj_y, input int inj_c);
    int idx, k, first_k, data_err, stab_err, done_err, first_bad, ex, ey;
    bit stalled;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    logic       hl;
    snap = fb;
    idx = 0; k = 0; first_k = -1; data_err = 0; stab_err = 0; done_err = 0; first_bad = -1;
    stalled = 1'b0; hx = '0; hy = '0; hc = '0; hl = 1'b0;
    pif.rd_start = 1'b1;
    @(posedge clk); #1;
    pif.rd_start = 1'b0;
    while (idx < NPIX && k < BUDGET && !(abort_at >= 0 && idx >= abort_at)) begin
      pif.pix_ready = (mode == 0) ? 1'b1 : ((k % 2) == 0);
      pif.rd_start  = (mode == 1) && ((k % 97) == 50);
      if (k == inj_k) begin
        pif.vga_x = 8'(inj_x); pif.vga_y = 7'(inj_y); pif.vga_colour = 3'(inj_c);
        pif.vga_plot = 1'b1;
        fb[inj_y][inj_x] = 3'(inj_c);
        exp_plot = sat16(exp_plot + 1);
      end else begin
        pif.vga_plot = 1'b0;
      end
      @(negedge clk);
      if (pif.pix_valid === 1'b1 && first_k < 0) first_k = k;
      if (pif.done !== 1'b0) done_err++;
      if (stalled && (pif.pix_valid !== 1'b1 || pif.pix_x !== hx || pif.pix_y !== hy ||
                      pif.pix_colour !== hc || pif.pix_last !== hl)) stab_err++;
      stalled = 1'b0;
      if (pif.pix_valid === 1'b1) begin
        if (pif.pix_ready === 1'b1) begin
          ex = idx % W;
          ey = idx / W;
          if (pif.pix_x !== 8'(ex) || pif.pix_y !== 7'(ey) || pif.pix_colour !== snap[ey][ex] ||
              pif.pix_last !== (idx == NPIX - 1)) begin
            if (data_err == 0) first_bad = idx;
            data_err++;
          end
          idx++;
        end else begin
          stalled = 1'b1;
          hx = pif.pix_x; hy = pif.pix_y; hc = pif.pix_colour; hl = pif.pix_last;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    pif.pix_ready = 1'b0;
    pif.rd_start  = 1'b0;
    pif.vga_plot  = 1'b0;

    checks++;
    if (first_k !== 2) begin
      errors++;
      $display("FAIL %s_first_valid_cycle got %0d exp 2", tag, first_k);
    end
    checks++;
    if (data_err !== 0) begin
      errors++;
      $display("FAIL %s_pixels got %0d bad (first at %0d) exp 0", tag, data_err, first_bad);
    end
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL %s_stall_stable got %0d changes exp 0", tag, stab_err);
    end
    checks++;
    if (done_err !== 0) begin
      errors++;
      $display("FAIL %s_done_during_scan got %0d cycles exp 0", tag, done_err);
    end

    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      exp_plot = 0;
      exp_drop = 0;
      checks++;
      if ({pif.pix_valid, pif.pix_x, pif.pix_y, pif.pix_colour, pif.pix_last, pif.done} !== 21'd0) begin
        errors++;
        $display("FAIL %s_reset_outputs got v%0b x%0d y%0d c%0d l%0b d%0b exp all 0", tag,
                 pif.pix_valid, pif.pix_x, pif.pix_y, pif.pix_colour, pif.pix_last, pif.done);
      end
      checks++;
      if (pif.plot_count !== 16'd0 || pif.drop_count !== 16'd0) begin
        errors++;
        $display("FAIL %s_reset_counters got %0d/%0d exp 0/0", tag, pif.plot_count, pif.drop_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      checks++;
      if (idx !== NPIX) begin
        errors++;
        $display("FAIL %s_transfer_count got %0d exp %0d", tag, idx, NPIX);
      end
      checks++;
      if (pif.done !== 1'b1 || pif.pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_after got done=%0b valid=%0b exp done=1 valid=0", tag, pif.done, pif.pix_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pif.pix_valid, pif.pix_x, pif.pix_y, pif.pix_colour, pif.pix_last, pif.done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got v%0b x%0d y%0d c%0d l%0b d%0b exp all 0",
               pif.pix_valid, pif.pix_x, pif.pix_y, pif.pix_colour, pif.pix_last, pif.done);
    end
    checks++;
    if (pif.plot_count !== 16'd0 || pif.drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", pif.plot_count, pif.drop_count);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pif.done !== 1'b0 || pif.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got done=%0b valid=%0b exp 0/0", pif.done, pif.pix_valid);
    end
  endtask

  task automatic test_fill();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        plot_px(x, y, 0);
    pif.vga_plot = 1'b0;
    checks++;
    if (pif.plot_count !== exp_cnt(exp_plot)) begin
      errors++;
      $display("FAIL fill_plot_count got %0d exp %0d", pif.plot_count, exp_cnt(exp_plot));
    end
  endtask

  task automatic test_drops();
    plot_px(160, 0, 7);
    plot_px(0, 120, 7);
    pif.vga_plot = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pif.drop_count !== exp_cnt(exp_drop)) begin
      errors++;
      $display("FAIL drops_drop_count got %0d exp %0d", pif.drop_count, exp_cnt(exp_drop));
    end
    checks++;
    if (pif.plot_count !== exp_cnt(exp_plot)) begin
      errors++;
      $display("FAIL drops_plot_count got %0d exp %0d", pif.plot_count, exp_cnt(exp_plot));
    end
  endtask

  task automatic test_random_plots();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pif.vga_plot = 1'b0;
        pif.vga_x    = 8'($urandom);
        @(posedge clk); #1;
      end else begin
        plot_px($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
      end
    end
    plot_px(5, 7, 3'b101);
    plot_px(159, 119, 3'b011);
    plot_px(2, 0, 3'b110);
    pif.vga_plot = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pif.plot_count !== exp_cnt(exp_plot) || pif.drop_count !== exp_cnt(exp_drop)) begin
      errors++;
      $display("FAIL random_counters got %0d/%0d exp %0d/%0d", pif.plot_count, pif.drop_count,
               exp_cnt(exp_plot), exp_cnt(exp_drop));
    end
  endtask

  task automatic test_backpressure();
    run_scan("toggle_scan", 1, -1, -1, 0, 0, 0);
  endtask

  task automatic test_rbw_and_reset();
    // Address 2 is read on the third edge after rd_start, the same edge as this plot
    run_scan("rbw_abort_scan", 0, 500, 2, 2, 0, 3'b001);
    run_scan("rescan", 0, -1, -1, 0, 0, 0);
    checks++;
    if (pif.plot_count !== exp_cnt(exp_plot) || pif.drop_count !== exp_cnt(exp_drop)) begin
      errors++;
      $display("FAIL rescan_counters got %0d/%0d exp %0d/%0d", pif.plot_count, pif.drop_count,
               exp_cnt(exp_plot), exp_cnt(exp_drop));
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_plot = 0; exp_drop = 0;
    pif.vga_x = '0; pif.vga_y = '0; pif.vga_colour = '0; pif.vga_plot = 1'b0;
    pif.rd_start = 1'b0; pif.pix_ready = 1'b0;
    test_reset();
    test_fill();
    test_drops();
    test_random_plots();
    test_backpressure();
    test_rbw_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
